spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Downstream readout stage for the LIF network. It consumes the output neuron's spike line and membrane state, and counts spikes over a programmable window of clock cycles. At the end of each window it presents the spike count (the decoded firing rate) and the peak membrane state seen, with a one-cycle valid strobe. Windows repeat back-to-back while enabled, so the network's spiking becomes a stream of numeric rate samples for the output pins or a host.

## Interface
- WINDOW_W, default 8: width of the window-length input and of the internal remaining-cycles counter.
- CNT_W, default 8: width of the spike counter and of `rate_out`.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  decode enable; high starts and continues windows, low aborts.
- window_len  input  WINDOW_W  window length in cycles; 0 encodes 2^WINDOW_W; sampled only at window start.
- spike_in  input  1  output-neuron spike (bit 0 of the network spike output).
- state_in  input  8  output-neuron membrane state, unsigned.
- rate_out  output  CNT_W  spike count of the last completed window, saturating.
- peak_out  output  8  maximum `state_in` sampled in the last completed window.
- overflow  output  1  set if the count saturated in the last completed window.
- rate_valid  output  1  one-cycle strobe marking a window's results are updated.
- busy  output  1  high while a window is in progress (state COUNT).

## Operation
- FSM states: IDLE and COUNT.
- IDLE, en=1 at an edge: go to COUNT.
  - Load `remaining` with N (N = `window_len`, or 2^WINDOW_W if 0).
  - Clear `cnt`, `peak` and `sat`. The spike at this edge is not counted.
- COUNT, en=1 at an edge (a sample edge):
  - If `spike_in`=1, `cnt` increments. At all-ones it holds and sets `sat`.
  - `peak` becomes max(`peak`, `state_in`).
  - `remaining` decrements.
- Last sample edge (`remaining`=1) at that same edge:
  - `rate_out` takes `cnt` + `spike_in`, saturated; `peak_out` takes the final max; `overflow` takes the final `sat`; `rate_valid` goes to 1.
  - If en=1: stay in COUNT, reload `remaining` from the current `window_len`, clear `cnt`, `peak` and `sat`. The next window's first sample is the next edge; there is no gap cycle.
  - If en=0: return to IDLE.
- COUNT, en=0 at any non-final edge: abort. Go to IDLE and discard partial counts. No `rate_valid`; `rate_out`, `peak_out` and `overflow` keep their previous values.
- `rate_out`, `peak_out` and `overflow` change only on a window-completion edge; otherwise they hold.
- Width rules:
  - `cnt` is CNT_W bits, saturating, never wrapping.
  - `remaining` is WINDOW_W+1 bits so 2^WINDOW_W is representable.
  - `peak` comparison is unsigned 8-bit.
- Changing `window_len` mid-window has no effect until the next window start.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; `rate_out`=0, `peak_out`=0, `overflow`=0, `rate_valid`=0, `busy`=0; internal counters 0. This takes priority over all other activity, including mid-window.
- `busy` is registered: it goes high the cycle after the start edge and low the cycle after the completion edge (unless back-to-back) or after the abort edge.
- Window of N samples:
  - Start edge E0, samples at E1..EN.
  - `rate_valid` is high for exactly the one cycle following EN.
  - The total latency from start edge to valid is N edges.
- Back-to-back windows: `rate_valid` pulses every N edges with no missed samples.
- `rate_valid` is never high for two consecutive cycles unless N=1 and en is held.

## Test plan
- Reset, then en=1, `window_len`=4, `spike_in`=1 held -> `rate_valid` for one cycle after E4, `rate_out`=4, `overflow`=0, `busy` high for E1..E4.
- `window_len`=8, spikes on E2, E5 and E7 only, `state_in` ramp 10, 20, …, 80 with 200 at E3 -> `rate_out`=3, `peak_out`=200.
- `window_len`=0 (256 cycles), `spike_in`=1 held -> `rate_out`=255, `overflow`=1, valid after E256.
- en held with `window_len`=3 and `spike_in` toggling -> valid pulses at E3, E6 and E9, each with `rate_out`=1 or 2 per the pattern, with no gap between windows.
- Complete a window with `rate_out`=4, then start `window_len`=6 and drop en at E3 -> no `rate_valid`, `rate_out` stays 4, `busy` falls the next cycle.
- Assert rst_n=0 at E2 of a window -> all outputs 0 the next cycle, IDLE; with en still 1 after release, a fresh window starts with a clean count.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Turns the output neuron's spike line into a stream of firing-rate samples.
// Spikes are counted over a programmable window of clock cycles. At the end of
// each window the saturated count, the peak membrane state and an overflow
// flag are published together with a one-cycle valid strobe. While en stays
// high, windows follow each other back-to-back with no gap cycle.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   en          high starts/continues windows, low aborts a window in progress
//   window_len  window length in cycles, 0 means 2^WINDOW_W; sampled at window start
//   spike_in    output-neuron spike
//   state_in    output-neuron membrane state, unsigned
//   rate_out    spike count of the last completed window (saturating)
//   peak_out    maximum state_in seen in the last completed window
//   overflow    count saturated in the last completed window
//   rate_valid  one-cycle strobe when the three result outputs update
//   busy        a window is in progress
//
// state | meaning
// IDLE  | no window running, waiting for en
// COUNT | sampling spike_in/state_in, remaining_q edges left in the window
module spike_rate_decoder #(
   parameter int WINDOW_W = 8,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [WINDOW_W-1:0] window_len,
   input  logic                spike_in,
   input  logic [7:0]          state_in,
   output logic [CNT_W-1:0]    rate_out,
   output logic [7:0]          peak_out,
   output logic                overflow,
   output logic                rate_valid,
   output logic                busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WINDOW_W:0]   remaining_q, remaining_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          peak_q, peak_d;
   logic                sat_q, sat_d;
   logic [CNT_W-1:0]    rate_out_q, rate_out_d;
   logic [7:0]          peak_out_q, peak_out_d;
   logic                overflow_q, overflow_d;
   logic                rate_valid_q, rate_valid_d;

   logic [WINDOW_W:0]   win_n;
   logic [CNT_W-1:0]    cnt_upd;
   logic                sat_upd;
   logic [7:0]          peak_upd;
   logic                last_edge;

   // Values the accumulators take if the current edge is a sample edge.
   always_comb begin
      win_n = {1'b0, window_len};
      if (window_len == '0) begin
         win_n = {1'b1, {WINDOW_W{1'b0}}};
      end

      cnt_upd = cnt_q;
      sat_upd = sat_q;
      if (spike_in) begin
         if (&cnt_q) begin
            sat_upd = 1'b1;
         end else begin
            cnt_upd = cnt_q + CNT_W'(1);
         end
      end

      peak_upd  = (state_in > peak_q) ? state_in : peak_q;
      last_edge = (remaining_q == (WINDOW_W+1)'(1));
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      cnt_d        = cnt_q;
      peak_d       = peak_q;
      sat_d        = sat_q;
      rate_out_d   = rate_out_q;
      peak_out_d   = peak_out_q;
      overflow_d   = overflow_q;
      rate_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d     = COUNT;
               remaining_d = win_n;
               cnt_d       = '0;
               peak_d      = '0;
               sat_d       = 1'b0;
            end
         end
         COUNT: begin
            if (last_edge) begin
               // The final sample completes the window even if en has dropped.
               rate_out_d   = cnt_upd;
               peak_out_d   = peak_upd;
               overflow_d   = sat_upd;
               rate_valid_d = 1'b1;
               cnt_d        = '0;
               peak_d       = '0;
               sat_d        = 1'b0;
               if (en) begin
                  remaining_d = win_n;
               end else begin
                  state_d     = IDLE;
                  remaining_d = '0;
               end
            end else if (en) begin
               cnt_d       = cnt_upd;
               peak_d      = peak_upd;
               sat_d       = sat_upd;
               remaining_d = remaining_q - (WINDOW_W+1)'(1);
            end else begin
               state_d     = IDLE;
               remaining_d = '0;
               cnt_d       = '0;
               peak_d      = '0;
               sat_d       = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         cnt_q        <= '0;
         peak_q       <= '0;
         sat_q        <= 1'b0;
         rate_out_q   <= '0;
         peak_out_q   <= '0;
         overflow_q   <= 1'b0;
         rate_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         cnt_q        <= cnt_d;
         peak_q       <= peak_d;
         sat_q        <= sat_d;
         rate_out_q   <= rate_out_d;
         peak_out_q   <= peak_out_d;
         overflow_q   <= overflow_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   assign rate_out   = rate_out_q;
   assign peak_out   = peak_out_q;
   assign overflow   = overflow_q;
   assign rate_valid = rate_valid_q;
   assign busy       = (state_q == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder with directed scenarios and a
// randomized back-to-back run, compared against a window-level reference model.
module tb_spike_rate_decoder;

   localparam int WINDOW_W = 8;
   localparam int CNT_W    = 8;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic [WINDOW_W-1:0] window_len = '0;
   logic                spike_in = 1'b0;
   logic [7:0]          state_in = '0;
   logic [CNT_W-1:0]    rate_out;
   logic [7:0]          peak_out;
   logic                overflow;
   logic                rate_valid;
   logic                busy;

   spike_rate_decoder #(.WINDOW_W(WINDOW_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .window_len (window_len),
      .spike_in   (spike_in),
      .state_in   (state_in),
      .rate_out   (rate_out),
      .peak_out   (peak_out),
      .overflow   (overflow),
      .rate_valid (rate_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a window is a list of samples; the result is the
   // unbounded spike total clipped to CMAX, and the max of the states.
   bit         m_active = 0;
   int         m_left   = 0;
   int         m_total  = 0;
   int         m_peak   = 0;
   logic [7:0] e_rate   = '0;
   logic [7:0] e_peak   = '0;
   bit         e_ovf    = 0;
   bit         e_valid  = 0;
   bit         e_busy   = 0;

   function automatic int win_cycles(input logic [WINDOW_W-1:0] wl);
      return (wl == 0) ? (1 << WINDOW_W) : int'(wl);
   endfunction

   // Advance DUT and model by one clock edge; returns 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_active = 0; m_left = 0; m_total = 0; m_peak = 0;
         e_rate = '0; e_peak = '0; e_ovf = 0; e_valid = 0;
      end else begin
         e_valid = 0;
         if (!m_active) begin
            if (en) begin
               m_active = 1; m_left = win_cycles(window_len);
               m_total = 0; m_peak = 0;
            end
         end else if (en || m_left == 1) begin
            m_total += int'(spike_in);
            if (int'(state_in) > m_peak) m_peak = int'(state_in);
            m_left--;
            if (m_left == 0) begin
               e_rate  = 8'((m_total > CMAX) ? CMAX : m_total);
               e_peak  = 8'(m_peak);
               e_ovf   = (m_total > CMAX);
               e_valid = 1;
               m_total = 0; m_peak = 0;
               if (en) m_left = win_cycles(window_len);
               else    m_active = 0;
            end
         end else begin
            m_active = 0; m_total = 0; m_peak = 0;
         end
      end
      e_busy = m_active;
      #1;
   endtask

   task automatic go_idle();
      en = 1'b0; spike_in = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; spike_in = 1'b1; window_len = 8'd3;
      repeat (3) tick();
      checks++;
      if ({rate_valid, busy, overflow, rate_out, peak_out} !== 19'd0) begin
         errors++;
         $display("FAIL reset: got v=%0b b=%0b o=%0b r=%0d p=%0d, want all zero",
                  rate_valid, busy, overflow, rate_out, peak_out);
      end
      en = 1'b0; spike_in = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      en = 1'b1; window_len = 8'd4; spike_in = 1'b1; state_in = 8'd7;
      tick();  // E0
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (busy !== 1'b1 || rate_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy E%0d: got b=%0b v=%0b, want b=1 v=0", k - 1, busy, rate_valid);
         end
         if (k == 4) en = 1'b0;
         tick();
      end
      checks++;
      if (rate_valid !== 1'b1 || rate_out !== 8'd4 || overflow !== 1'b0 || busy !== 1'b0 ||
          peak_out !== e_peak) begin
         errors++;
         $display("FAIL basic_result: got v=%0b r=%0d o=%0b b=%0b p=%0d, want v=1 r=4 o=0 b=0 p=%0d",
                  rate_valid, rate_out, overflow, busy, peak_out, e_peak);
      end
      tick();
      checks++;
      if (rate_valid !== 1'b0 || rate_out !== 8'd4) begin
         errors++;
         $display("FAIL basic_hold: got v=%0b r=%0d, want v=0 r=4", rate_valid, rate_out);
      end
   endtask

   task automatic test_peak();
      en = 1'b1; window_len = 8'd8; spike_in = 1'b1; state_in = 8'd250;
      tick();  // E0: spike and state here are ignored
      for (int k = 1; k <= 8; k++) begin
         spike_in = (k == 2 || k == 5 || k == 7);
         state_in = (k == 3) ? 8'd200 : 8'(10 * k);
         if (k == 8) en = 1'b0;
         tick();
         checks++;
         if (rate_valid !== (k == 8) || rate_valid !== e_valid || busy !== e_busy) begin
            errors++;
            $display("FAIL peak_timing E%0d: got v=%0b b=%0b, want v=%0b b=%0b",
                     k, rate_valid, busy, e_valid, e_busy);
         end
      end
      checks++;
      if (rate_out !== 8'd3 || peak_out !== 8'd200 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL peak_result: got r=%0d p=%0d o=%0b, want r=3 p=200 o=0",
                  rate_out, peak_out, overflow);
      end
      go_idle();
   endtask

   task automatic test_full_window();
      en = 1'b1; window_len = 8'd0; spike_in = 1'b1;
      tick();  // E0
      for (int k = 1; k <= 256; k++) begin
         state_in = 8'($urandom_range(0, 254));
         if (k == 256) en = 1'b0;
         tick();
         checks++;
         if (rate_valid !== (k == 256) || busy !== e_busy) begin
            errors++;
            $display("FAIL full_timing E%0d: got v=%0b b=%0b, want v=%0b b=%0b",
                     k, rate_valid, busy, (k == 256), e_busy);
         end
      end
      checks++;
      if (rate_out !== 8'd255 || overflow !== 1'b1 || peak_out !== e_peak) begin
         errors++;
         $display("FAIL full_result: got r=%0d o=%0b p=%0d, want r=255 o=1 p=%0d",
                  rate_out, overflow, peak_out, e_peak);
      end
      go_idle();
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [3];
      int         w;
      want[0] = 8'd2; want[1] = 8'd1; want[2] = 8'd2;
      w = 0;
      en = 1'b1; window_len = 8'd3;
      for (int k = 0; k <= 9; k++) begin
         spike_in = (k % 2 == 1);
         tick();
         if (k >= 1) begin
            checks++;
            if (rate_valid !== (k % 3 == 0) || busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_timing E%0d: got v=%0b b=%0b, want v=%0b b=1",
                        k, rate_valid, busy, (k % 3 == 0));
            end
            if (k % 3 == 0) begin
               checks++;
               if (rate_out !== want[w]) begin
                  errors++;
                  $display("FAIL b2b_rate window %0d: got r=%0d, want r=%0d", w, rate_out, want[w]);
               end
               w++;
            end
         end
      end
      // Randomized continuation, including N=1 and window_len changing mid-window.
      for (int c = 0; c < 400; c++) begin
         en         = ($urandom_range(0, 15) != 0);
         window_len = 8'($urandom_range(1, 5));
         spike_in   = 1'($urandom_range(0, 1));
         state_in   = 8'($urandom);
         tick();
         checks++;
         if ({rate_valid, busy, overflow, rate_out, peak_out} !==
             {e_valid, e_busy, e_ovf, e_rate, e_peak}) begin
            errors++;
            $display("FAIL random c=%0d: got v=%0b b=%0b o=%0b r=%0d p=%0d, want v=%0b b=%0b o=%0b r=%0d p=%0d",
                     c, rate_valid, busy, overflow, rate_out, peak_out,
                     e_valid, e_busy, e_ovf, e_rate, e_peak);
         end
      end
      go_idle();
   endtask

   task automatic test_abort();
      en = 1'b1; window_len = 8'd4; spike_in = 1'b1;
      tick();
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) en = 1'b0;
         tick();
      end
      checks++;
      if (rate_valid !== 1'b1 || rate_out !== 8'd4) begin
         errors++;
         $display("FAIL abort_setup: got v=%0b r=%0d, want v=1 r=4", rate_valid, rate_out);
      end
      en = 1'b1; window_len = 8'd6;
      tick();  // E0
      tick();  // E1
      tick();  // E2
      en = 1'b0;
      tick();  // E3 aborts
      checks++;
      if (rate_valid !== 1'b0 || rate_out !== 8'd4 || busy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL abort: got v=%0b r=%0d b=%0b o=%0b, want v=0 r=4 b=0 o=0",
                  rate_valid, rate_out, busy, overflow);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (rate_valid !== 1'b0 || rate_out !== 8'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold c=%0d: got v=%0b r=%0d b=%0b, want v=0 r=4 b=0",
                     k, rate_valid, rate_out, busy);
         end
      end
   endtask

   task automatic test_reset_mid_window();
      en = 1'b1; window_len = 8'd5; spike_in = 1'b1; state_in = 8'd99;
      tick();  // E0
      tick();  // E1
      rst_n = 1'b0;
      tick();  // E2 under reset
      checks++;
      if ({rate_valid, busy, overflow, rate_out, peak_out} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid: got v=%0b b=%0b o=%0b r=%0d p=%0d, want all zero",
                  rate_valid, busy, overflow, rate_out, peak_out);
      end
      rst_n = 1'b1; window_len = 8'd2; state_in = 8'd33;
      tick();  // fresh E0
      checks++;
      if (busy !== 1'b1 || rate_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_restart: got b=%0b v=%0b, want b=1 v=0", busy, rate_valid);
      end
      tick();  // E1
      en = 1'b0;
      tick();  // E2 completes
      checks++;
      if (rate_valid !== 1'b1 || rate_out !== 8'd2 || peak_out !== 8'd33 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_fresh: got v=%0b r=%0d p=%0d o=%0b, want v=1 r=2 p=33 o=0",
                  rate_valid, rate_out, peak_out, overflow);
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_peak();
      test_full_window();
      test_back_to_back();
      test_abort();
      test_reset_mid_window();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
